// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Fetch looks up combinationally; Execute trains and allocates on the clock edge.
module branch_target_buffer #(
    parameter int ADDR_WIDTH   = 32,
    parameter int ENTRIES      = 64,
    parameter int COUNTER_BITS = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [ADDR_WIDTH-1:0]       fetchAddress,
    output logic                        branchPredictValid,
    output logic [ADDR_WIDTH-1:0]       branchPredictData,
    input  logic                        updateValid,
    input  logic [ADDR_WIDTH-1:0]       updateAddress,
    input  logic                        updateTaken,
    input  logic [ADDR_WIDTH-1:0]       updateTarget,
    input  logic                        flush,
    output logic [$clog2(ENTRIES):0]    validCount
);
    localparam int INDEX_BITS = $clog2(ENTRIES);
    localparam int TAG_BITS   = ADDR_WIDTH - INDEX_BITS - 2;

    localparam logic [COUNTER_BITS-1:0] CTR_ONE    = COUNTER_BITS'(1);
    localparam logic [COUNTER_BITS-1:0] CTR_MAX    = '1;
    localparam logic [COUNTER_BITS-1:0] WEAK_TAKEN = CTR_ONE << (COUNTER_BITS - 1);
    localparam logic [INDEX_BITS:0]     CNT_ONE    = (INDEX_BITS + 1)'(1);

    logic [ENTRIES-1:0]      valid;
    logic [TAG_BITS-1:0]     tag_mem     [ENTRIES];
    logic [ADDR_WIDTH-1:0]   target_mem  [ENTRIES];
    logic [COUNTER_BITS-1:0] counter_mem [ENTRIES];

    logic [INDEX_BITS-1:0] fetch_idx;
    logic [TAG_BITS-1:0]   fetch_tag;
    logic                  fetch_hit;
    logic [INDEX_BITS-1:0] upd_idx;
    logic [TAG_BITS-1:0]   upd_tag;
    logic                  upd_hit;
    logic                  do_update;
    logic                  do_alloc;
    logic                  unused_low_bits;

    // Instructions are word aligned, so the two lowest PC bits carry no information.
    assign unused_low_bits = ^{fetchAddress[1:0], updateAddress[1:0]};

    assign fetch_idx = fetchAddress[INDEX_BITS+1:2];
    assign fetch_tag = fetchAddress[ADDR_WIDTH-1:INDEX_BITS+2];
    assign upd_idx   = updateAddress[INDEX_BITS+1:2];
    assign upd_tag   = updateAddress[ADDR_WIDTH-1:INDEX_BITS+2];

    assign fetch_hit = valid[fetch_idx] && (tag_mem[fetch_idx] == fetch_tag);
    assign upd_hit   = valid[upd_idx] && (tag_mem[upd_idx] == upd_tag);

    assign branchPredictValid = fetch_hit && counter_mem[fetch_idx][COUNTER_BITS-1];
    assign branchPredictData  = branchPredictValid ? target_mem[fetch_idx] : '0;

    assign do_update = updateValid && !flush && !reset;
    assign do_alloc  = do_update && !upd_hit && updateTaken;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid      <= '0;
            validCount <= '0;
        end else if (flush) begin
            valid      <= '0;
            validCount <= '0;
        end else if (do_alloc) begin
            valid[upd_idx] <= 1'b1;
            if (!valid[upd_idx]) begin
                validCount <= validCount + CNT_ONE;
            end
        end
    end

    // Payload arrays are deliberately left unreset; the valid bits gate every use.
    always_ff @(posedge clock) begin
        if (do_update) begin
            if (upd_hit) begin
                if (updateTaken) begin
                    target_mem[upd_idx] <= updateTarget;
                    if (counter_mem[upd_idx] != CTR_MAX) begin
                        counter_mem[upd_idx] <= counter_mem[upd_idx] + CTR_ONE;
                    end
                end else if (counter_mem[upd_idx] != '0) begin
                    counter_mem[upd_idx] <= counter_mem[upd_idx] - CTR_ONE;
                end
            end else if (updateTaken) begin
                tag_mem[upd_idx]     <= upd_tag;
                target_mem[upd_idx]  <= updateTarget;
                counter_mem[upd_idx] <= WEAK_TAKEN;
            end
        end
    end
endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: directed vector table, corner
// sequences, then randomized traffic against an abstract reference model.
module tb_branch_target_buffer;
    localparam int AW = 32;
    localparam int N  = 64;

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] fetchAddress;
    logic          branchPredictValid;
    logic [AW-1:0] branchPredictData;
    logic          updateValid;
    logic [AW-1:0] updateAddress;
    logic          updateTaken;
    logic [AW-1:0] updateTarget;
    logic          flush;
    logic [6:0]    validCount;

    int tests = 0;
    int fails = 0;

    branch_target_buffer #(.ADDR_WIDTH(AW), .ENTRIES(N), .COUNTER_BITS(2)) dut (
        .clock              (clock),
        .reset              (reset),
        .fetchAddress       (fetchAddress),
        .branchPredictValid (branchPredictValid),
        .branchPredictData  (branchPredictData),
        .updateValid        (updateValid),
        .updateAddress      (updateAddress),
        .updateTaken        (updateTaken),
        .updateTarget       (updateTarget),
        .flush              (flush),
        .validCount         (validCount)
    );

    always #5 clock = ~clock;

    // Reference model: each slot remembers the whole word address that owns it
    // and a direction strength 0..3, where strength >= 2 means "taken".
    bit          m_valid  [N];
    logic [29:0] m_word   [N];
    logic [31:0] m_target [N];
    int          m_str    [N];

    typedef struct {
        logic        uv;
        logic [31:0] ua;
        logic        ut;
        logic [31:0] utg;
        logic        fl;
        logic [31:0] la;
        logic        exp_pv;
        logic [31:0] exp_pd;
        int          exp_cnt;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int slot(input logic [31:0] a);
        return int'(a[31:2]) % N;
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        return m_valid[slot(a)] && (m_word[slot(a)] == a[31:2]);
    endfunction

    function automatic bit m_pv(input logic [31:0] a);
        return m_hit(a) && (m_str[slot(a)] >= 2);
    endfunction

    function automatic logic [31:0] m_pd(input logic [31:0] a);
        return m_pv(a) ? m_target[slot(a)] : 32'h0;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < N; i++) c += m_valid[i] ? 1 : 0;
        return c;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    endtask

    task automatic m_step(input logic uv, input logic [31:0] ua, input logic ut,
                          input logic [31:0] utg, input logic fl);
        int s;
        s = slot(ua);
        if (fl) m_clear();
        else if (uv) begin
            if (m_hit(ua)) begin
                if (ut) begin
                    m_str[s]    = (m_str[s] < 3) ? m_str[s] + 1 : 3;
                    m_target[s] = utg;
                end else begin
                    m_str[s] = (m_str[s] > 0) ? m_str[s] - 1 : 0;
                end
            end else if (ut) begin
                m_valid[s]  = 1'b1;
                m_word[s]   = ua[31:2];
                m_target[s] = utg;
                m_str[s]    = 2;
            end
        end
    endtask

    task automatic idle_inputs();
        updateValid   = 1'b0;
        updateAddress = '0;
        updateTaken   = 1'b0;
        updateTarget  = '0;
        flush         = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        fetchAddress = '0;
        reset = 1'b1;
        @(posedge clock);
        #2 reset = 1'b0;
        m_clear();
    endtask

    // Drive one update (after the current edge), clock it, then look up.
    task automatic upd(input logic uv, input logic [31:0] ua, input logic ut,
                       input logic [31:0] utg, input logic fl);
        updateValid = uv; updateAddress = ua; updateTaken = ut;
        updateTarget = utg; flush = fl;
        @(posedge clock);
        #1 idle_inputs();
    endtask

    initial begin
        logic        r_uv, r_ut, r_fl;
        logic [31:0] r_ua, r_utg, r_la;

        reset = 1'b1;
        idle_inputs();
        fetchAddress = '0;

        //            uv    ua          ut    utg         fl    la          pv    pd          cnt
        vecs[0]  = '{1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 32'h100,    1'b0, 32'h0,      0};
        vecs[1]  = '{1'b1, 32'h100,    1'b1, 32'h200,    1'b0, 32'h100,    1'b1, 32'h200,    1};
        vecs[2]  = '{1'b1, 32'h100,    1'b1, 32'h200,    1'b0, 32'h100,    1'b1, 32'h200,    1};
        vecs[3]  = '{1'b1, 32'h100,    1'b1, 32'h200,    1'b0, 32'h100,    1'b1, 32'h200,    1};
        vecs[4]  = '{1'b1, 32'h100,    1'b1, 32'h200,    1'b0, 32'h100,    1'b1, 32'h200,    1};
        vecs[5]  = '{1'b1, 32'h100,    1'b0, 32'h0,      1'b0, 32'h100,    1'b1, 32'h200,    1};
        vecs[6]  = '{1'b1, 32'h100,    1'b0, 32'h0,      1'b0, 32'h100,    1'b0, 32'h0,      1};
        vecs[7]  = '{1'b1, 32'h200,    1'b1, 32'h300,    1'b0, 32'h100,    1'b0, 32'h0,      1};
        vecs[8]  = '{1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 32'h200,    1'b1, 32'h300,    1};
        vecs[9]  = '{1'b1, 32'h404,    1'b0, 32'h0,      1'b0, 32'h404,    1'b0, 32'h0,      1};
        vecs[10] = '{1'b1, 32'h404,    1'b1, 32'h800,    1'b0, 32'h404,    1'b1, 32'h800,    2};
        vecs[11] = '{1'b1, 32'h404,    1'b1, 32'h900,    1'b0, 32'h404,    1'b1, 32'h900,    2};
        vecs[12] = '{1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 32'h407,    1'b1, 32'h900,    2};
        vecs[13] = '{1'b1, 32'h200,    1'b0, 32'h0,      1'b0, 32'h200,    1'b0, 32'h0,      2};

        #3 check("async_reset_pv", {31'b0, branchPredictValid}, 32'h0);
        do_reset();

        for (int i = 0; i < 14; i++) begin
            upd(vecs[i].uv, vecs[i].ua, vecs[i].ut, vecs[i].utg, vecs[i].fl);
            fetchAddress = vecs[i].la;
            #1;
            check($sformatf("vec%0d_pv", i), {31'b0, branchPredictValid}, {31'b0, vecs[i].exp_pv});
            check($sformatf("vec%0d_pd", i), branchPredictData, vecs[i].exp_pd);
            check($sformatf("vec%0d_cnt", i), {25'b0, validCount}, 32'(vecs[i].exp_cnt));
        end

        // No write-to-read bypass: the allocating update is invisible until after its edge.
        updateValid = 1'b1; updateAddress = 32'h508; updateTaken = 1'b1; updateTarget = 32'hA0;
        fetchAddress = 32'h508;
        #1 check("nobypass_before", {31'b0, branchPredictValid}, 32'h0);
        @(posedge clock);
        #1 idle_inputs();
        #1 check("nobypass_after", branchPredictData, 32'hA0);

        // Fill every index, then flush together with an update.
        do_reset();
        for (int i = 0; i < N; i++) upd(1'b1, 32'(i * 4), 1'b1, 32'(32'h1000 + i), 1'b0);
        check("fill_count", {25'b0, validCount}, 32'd64);
        fetchAddress = 32'hFC;
        #1 check("fill_last", branchPredictData, 32'h103F);
        upd(1'b1, 32'h0, 1'b1, 32'h55, 1'b1);
        check("flush_count", {25'b0, validCount}, 32'd0);
        for (int i = 0; i < N; i++) begin
            fetchAddress = 32'(i * 4);
            #0.1;
            check($sformatf("flush_miss%0d", i), {31'b0, branchPredictValid}, 32'h0);
        end

        // Asynchronous reset in the middle of a cycle with an update in flight.
        upd(1'b1, 32'h10, 1'b1, 32'h77, 1'b0);
        fetchAddress = 32'h10;
        #1 check("pre_reset_pd", branchPredictData, 32'h77);
        updateValid = 1'b1; updateAddress = 32'h14; updateTaken = 1'b1; updateTarget = 32'h99;
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("midreset_pv", {31'b0, branchPredictValid}, 32'h0);
        check("midreset_pd", branchPredictData, 32'h0);
        check("midreset_cnt", {25'b0, validCount}, 32'h0);
        @(posedge clock);
        #1 check("reset_drops_update", {25'b0, validCount}, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1 idle_inputs();
        fetchAddress = 32'h14;
        #1 check("first_update_after_reset", branchPredictData, 32'h99);

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            r_uv  = ($urandom_range(3) != 0);
            r_ut  = ($urandom_range(9) < 6);
            r_fl  = ($urandom_range(79) == 0);
            r_ua  = {22'b0, 2'($urandom_range(3)), 6'($urandom_range(N - 1)), 2'($urandom_range(3))};
            r_utg = $urandom;
            r_la  = ($urandom_range(3) == 0) ? r_ua :
                    {22'b0, 2'($urandom_range(3)), 6'($urandom_range(N - 1)), 2'($urandom_range(3))};
            updateValid = r_uv; updateAddress = r_ua; updateTaken = r_ut;
            updateTarget = r_utg; flush = r_fl; fetchAddress = r_la;
            #1;
            check("rand_pv", {31'b0, branchPredictValid}, {31'b0, m_pv(r_la)});
            check("rand_pd", branchPredictData, m_pd(r_la));
            check("rand_cnt", {25'b0, validCount}, 32'(m_count()));
            @(posedge clock);
            m_step(r_uv, r_ua, r_ut, r_utg, r_fl);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
